vball_video_timing: RTL and testbench
=====================================

// Module: vball_video_timing
// PURPOSE
//  Parametrised raster timing generator for the VBall video path: H/V counters, blank/sync, flip-aware pixel coords.
//  Also generates CPU interrupts: NMI at a set line, IRQ every 2^IRQ_LOG2 lines, both latched until acked.
//  Runs from the system clock with a pixel clock-enable; feeds tile/sprite renderers, the CPU interrupt
//  inputs and the video output stage.
// PARAMETERS
//  CNT_W       9    counter width (hcount, vcount, coordinates)
//  H_TOTAL     400  pixels per line; hcount runs 0..H_TOTAL-1
//  H_BLANK_END 1    first active pixel
//  H_BLANK_ST  241  first blanked pixel; active width H_ACT = H_BLANK_ST-H_BLANK_END
//  H_SYNC_ST   298  first hsync pixel; H_SYNC_END 330 is the first pixel after hsync
//  V_TOTAL     259  lines per frame; vcount runs 0..V_TOTAL-1
//  V_BLANK_ST  240  first blanked line; lines 0..V_BLANK_ST-1 are active
//  V_SYNC_ST   249  first vsync line; V_SYNC_END 252 is the first line after vsync
//  NMI_LINE    240  line whose pixel 0 raises NMI
//  IRQ_LOG2    3    IRQ raised on pixel 0 of lines where vcount[IRQ_LOG2-1:0] is all ones
//  SYNC_NEG    1    1: hs/vs active-low; 0: active-high
// PORTS
//  clk       in   1      system clock
//  reset     in   1      synchronous, active-high
//  ce_pix    in   1      pixel clock enable; all state advances only when high
//  flip      in   1      screen flip request
//  nmi_en    in   1      NMI enable; low clears and blocks nmi_pend
//  irq_en    in   1      IRQ enable; low clears and blocks irq_pend
//  nmi_ack   in   1      clears nmi_pend
//  irq_ack   in   1      clears irq_pend
//  hcount    out  CNT_W  raw horizontal count
//  vcount    out  CNT_W  raw vertical count
//  pix_x     out  CNT_W  active-area x, flip-corrected
//  pix_y     out  CNT_W  active-area y, flip-corrected
//  hb, vb    out  1      horizontal/vertical blank, active-high
//  hs, vs    out  1      sync, polarity per SYNC_NEG
//  nmi_pend  out  1      latched NMI request
//  irq_pend  out  1      latched IRQ request
//  frame_cnt out  8      frame counter
// BEHAVIOUR
//  Reset:
//   - hcount=vcount=0, pix_x=pix_y=0, hb=1, vb=0, hs/vs inactive, nmi_pend=irq_pend=0, frame_cnt=0,
//     flip_q=0.
//   - Reset overrides ce_pix and restarts a frame mid-line.
//  On each ce_pix cycle:
//   - hcount increments.
//   - At H_TOTAL-1, hcount wraps to 0 and vcount increments.
//   - At vcount V_TOTAL-1 with that wrap, vcount goes to 0 and frame_cnt+1 (mod 256).
//  Timing outputs are registered and valid in the same cycle as the counters they describe:
//   - hb = (hcount<H_BLANK_END)|(hcount>=H_BLANK_ST)
//   - vb = vcount>=V_BLANK_ST
//   - hs active iff H_SYNC_ST<=hcount<H_SYNC_END
//   - vs active iff V_SYNC_ST<=vcount<V_SYNC_END
//  Flip:
//   - flip is sampled into flip_q only at the wrap into hcount=0, vcount=0 (no mid-frame tearing).
//   - x = hcount-H_BLANK_END, y = vcount, both mod 2^CNT_W.
//   - pix_x = flip_q ? H_ACT-1-x : x;  pix_y = flip_q ? V_BLANK_ST-1-y : y.
//   - Outside the active area the value is don't-care but deterministic, per the same formula.
//  Interrupt events: single ce_pix cycle in which the counters newly equal the trigger point.
//   - NMI point: (NMI_LINE, 0).  IRQ point: (line matching IRQ_LOG2, 0).
//  Pending bits:
//   - Set on event if the enable is high; cleared on ack; set wins over ack in the same cycle.
//   - An enable low forces pending to 0 that cycle.
//   - ack is honoured regardless of ce_pix.
//  ce_pix low: every output holds. Continuous ce_pix=1 gives exactly H_TOTAL*V_TOTAL cycles per frame.
// STRUCTURE
//  Package vball_video_pkg holds:
//   - default timing localparams for the VBall raster (values above);
//   - function sync_lvl(active, neg) -> pin level.
//  Sub-module vball_int_latch: set/ack/enable pending flop with set-priority; instantiated twice (NMI, IRQ).
//  Counters, decode and flip logic stay in this module.
// TESTING
//  1. Reset, ce_pix=1 for 103600 cycles:
//     - frame_cnt 0->1 exactly at cycle 103600;
//     - hs low 32 cycles per line;
//     - vs low 3 lines.
//  2. IRQ cadence, irq_en=1, ack 2 cycles after each rise:
//     - irq_pend rises at pixel 0 of lines 7,15,...,255: 32 rises per frame.
//  3. nmi_en=1, no ack:
//     - nmi_pend sets at (240,0) and stays 1 across the frame.
//     - nmi_ack coincident with the next (240,0) event leaves nmi_pend=1.
//  4. flip raised mid-frame at line 100:
//     - pix_x unchanged until the next frame.
//     - Then at hcount=1, vcount=0: pix_x=239, pix_y=239.
//  5. ce_pix toggled 1-of-3:
//     - counts advance every third cycle and all outputs hold between enables.
//     - Reset asserted at hcount=200 returns all outputs to reset values next cycle.
//  6. Rebuild with SYNC_NEG=0, IRQ_LOG2=4:
//     - hs/vs active-high;
//     - irq_pend on lines 15,31,...,255 only.

Source files
------------

// File: rtl/vball_video_pkg.sv
// Purpose: shared raster defaults and helpers for the VBall video timing path.
// Latency: n/a (package).
// Backpressure: n/a.
package vball_video_pkg;

  // Default VBall raster: 400 x 259 total, 240 x 240 active.
  localparam int DEF_CNT_W       = 9;
  localparam int DEF_H_TOTAL     = 400;
  localparam int DEF_H_BLANK_END = 1;
  localparam int DEF_H_BLANK_ST  = 241;
  localparam int DEF_H_SYNC_ST   = 298;
  localparam int DEF_H_SYNC_END  = 330;
  localparam int DEF_V_TOTAL     = 259;
  localparam int DEF_V_BLANK_ST  = 240;
  localparam int DEF_V_SYNC_ST   = 249;
  localparam int DEF_V_SYNC_END  = 252;
  localparam int DEF_NMI_LINE    = 240;
  localparam int DEF_IRQ_LOG2    = 3;
  localparam int DEF_SYNC_NEG    = 1;

  // Convert a logical "sync active" flag to the pin level for the chosen polarity.
  function automatic logic sync_lvl(input logic active, input logic neg);
    return active ^ neg;
  endfunction

endpackage

// File: rtl/vball_int_latch.sv
// Purpose: latched interrupt request with set priority over ack, cleared by enable low.
// Latency: one cycle from set/ack/en to pend.
// Backpressure: none; ack acts on every clock, independent of the pixel enable.
module vball_int_latch (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic ack,
  input  logic en,
  output logic pend
);

  logic pend_q, pend_d;

  // Next pending state: disable clears, a new event beats a same-cycle ack.
  always_comb begin
    pend_d = pend_q;
    if (!en) begin
      pend_d = 1'b0;
    end else if (set) begin
      pend_d = 1'b1;
    end else if (ack) begin
      pend_d = 1'b0;
    end
  end

  // Pending flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;

endmodule

// File: rtl/vball_video_timing.sv
// Purpose: VBall raster counters, blank/sync decode, flip-aware pixel coords and CPU interrupts.
// Latency: decoded outputs are registered alongside the counters they describe (zero relative skew).
// Backpressure: none; ce_pix low freezes every output.
module vball_video_timing
  import vball_video_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int H_TOTAL     = DEF_H_TOTAL,
  parameter int H_BLANK_END = DEF_H_BLANK_END,
  parameter int H_BLANK_ST  = DEF_H_BLANK_ST,
  parameter int H_SYNC_ST   = DEF_H_SYNC_ST,
  parameter int H_SYNC_END  = DEF_H_SYNC_END,
  parameter int V_TOTAL     = DEF_V_TOTAL,
  parameter int V_BLANK_ST  = DEF_V_BLANK_ST,
  parameter int V_SYNC_ST   = DEF_V_SYNC_ST,
  parameter int V_SYNC_END  = DEF_V_SYNC_END,
  parameter int NMI_LINE    = DEF_NMI_LINE,
  parameter int IRQ_LOG2    = DEF_IRQ_LOG2,
  parameter int SYNC_NEG    = DEF_SYNC_NEG
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce_pix,
  input  logic             flip,
  input  logic             nmi_en,
  input  logic             irq_en,
  input  logic             nmi_ack,
  input  logic             irq_ack,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             hb,
  output logic             vb,
  output logic             hs,
  output logic             vs,
  output logic             nmi_pend,
  output logic             irq_pend,
  output logic [7:0]       frame_cnt
);

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] X_MAX  = CNT_W'(H_BLANK_ST - H_BLANK_END - 1);
  localparam logic [CNT_W-1:0] Y_MAX  = CNT_W'(V_BLANK_ST - 1);
  localparam logic             SNEG   = (SYNC_NEG != 0);

  logic [CNT_W-1:0] hcount_q, hcount_d, vcount_q, vcount_d;
  logic [CNT_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d, x_off;
  logic             hb_q, hb_d, vb_q, vb_d, hs_q, hs_d, vs_q, vs_d;
  logic             flip_q, flip_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             line_wrap, nmi_evt, irq_evt;

  // Raster counters; flip is only latched on the wrap into a new frame.
  always_comb begin
    hcount_d    = hcount_q;
    vcount_d    = vcount_q;
    frame_cnt_d = frame_cnt_q;
    flip_d      = flip_q;
    if (ce_pix) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        if (vcount_q == V_LAST) begin
          vcount_d    = '0;
          frame_cnt_d = frame_cnt_q + 8'd1;
          flip_d      = flip;
        end else begin
          vcount_d = vcount_q + ONE;
        end
      end else begin
        hcount_d = hcount_q + ONE;
      end
    end
  end

  // Decode from the next counter values so registered outputs line up with the counters.
  always_comb begin
    hb_d    = hb_q;
    vb_d    = vb_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    pix_x_d = pix_x_q;
    pix_y_d = pix_y_q;
    x_off   = hcount_d - CNT_W'(H_BLANK_END);
    if (ce_pix) begin
      hb_d    = (hcount_d < CNT_W'(H_BLANK_END)) | (hcount_d >= CNT_W'(H_BLANK_ST));
      vb_d    = (vcount_d >= CNT_W'(V_BLANK_ST));
      hs_d    = sync_lvl((hcount_d >= CNT_W'(H_SYNC_ST)) && (hcount_d < CNT_W'(H_SYNC_END)), SNEG);
      vs_d    = sync_lvl((vcount_d >= CNT_W'(V_SYNC_ST)) && (vcount_d < CNT_W'(V_SYNC_END)), SNEG);
      pix_x_d = flip_d ? (X_MAX - x_off) : x_off;
      pix_y_d = flip_d ? (Y_MAX - vcount_d) : vcount_d;
    end
  end

  // Interrupt events fire once, on the pixel-enable that wraps onto pixel 0 of the trigger line.
  assign line_wrap = ce_pix & (hcount_q == H_LAST);
  assign nmi_evt   = line_wrap & (vcount_d == CNT_W'(NMI_LINE));
  assign irq_evt   = line_wrap & (&vcount_d[IRQ_LOG2-1:0]);

  // State registers; reset forces a fresh frame regardless of ce_pix.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcount_q    <= '0;
      vcount_q    <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      hb_q        <= 1'b1;
      vb_q        <= 1'b0;
      hs_q        <= sync_lvl(1'b0, SNEG);
      vs_q        <= sync_lvl(1'b0, SNEG);
      flip_q      <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      hb_q        <= hb_d;
      vb_q        <= vb_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      flip_q      <= flip_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  vball_int_latch u_nmi (
    .clk   (clk),
    .reset (reset),
    .set   (nmi_evt),
    .ack   (nmi_ack),
    .en    (nmi_en),
    .pend  (nmi_pend)
  );

  vball_int_latch u_irq (
    .clk   (clk),
    .reset (reset),
    .set   (irq_evt),
    .ack   (irq_ack),
    .en    (irq_en),
    .pend  (irq_pend)
  );

  assign hcount    = hcount_q;
  assign vcount    = vcount_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign hb        = hb_q;
  assign vb        = vb_q;
  assign hs        = hs_q;
  assign vs        = vs_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vball_video_timing.sv
// Purpose: directed bench for vball_video_timing on the default raster and two shrunken rasters.
// Latency: n/a.
// Backpressure: n/a.
module tb_vball_video_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Default raster instance.
  logic       d_reset, d_ce, d_flip, d_nmi_en, d_irq_en, d_nmi_ack, d_irq_ack;
  logic [8:0] d_hcount, d_vcount, d_pix_x, d_pix_y;
  logic       d_hb, d_vb, d_hs, d_vs, d_nmi, d_irq;
  logic [7:0] d_frame;

  // Shrunken rasters (16 x 40, active 10 x 34); s1 active-low sync / IRQ every 8 lines,
  // s2 active-high sync / IRQ every 16 lines.
  logic       s_reset, s_ce, s_flip, s_nmi_en, s_irq_en;
  logic       s1_nmi_ack, s1_irq_ack, s2_nmi_ack, s2_irq_ack;
  logic [8:0] s1_hcount, s1_vcount, s1_pix_x, s1_pix_y, s2_hcount, s2_vcount, s2_pix_x, s2_pix_y;
  logic       s1_hb, s1_vb, s1_hs, s1_vs, s1_nmi_pend, s1_irq_pend;
  logic       s2_hb, s2_vb, s2_hs, s2_vs, s2_nmi_pend, s2_irq_pend;
  logic [7:0] s1_frame, s2_frame;

  vball_video_timing d_dut (
    .clk(clk), .reset(d_reset), .ce_pix(d_ce), .flip(d_flip), .nmi_en(d_nmi_en), .irq_en(d_irq_en),
    .nmi_ack(d_nmi_ack), .irq_ack(d_irq_ack), .hcount(d_hcount), .vcount(d_vcount), .pix_x(d_pix_x),
    .pix_y(d_pix_y), .hb(d_hb), .vb(d_vb), .hs(d_hs), .vs(d_vs), .nmi_pend(d_nmi), .irq_pend(d_irq),
    .frame_cnt(d_frame)
  );

  vball_video_timing #(
    .CNT_W(9), .H_TOTAL(16), .H_BLANK_END(1), .H_BLANK_ST(11), .H_SYNC_ST(12), .H_SYNC_END(14),
    .V_TOTAL(40), .V_BLANK_ST(34), .V_SYNC_ST(36), .V_SYNC_END(38), .NMI_LINE(34), .IRQ_LOG2(3),
    .SYNC_NEG(1)
  ) s1_dut (
    .clk(clk), .reset(s_reset), .ce_pix(s_ce), .flip(s_flip), .nmi_en(s_nmi_en), .irq_en(s_irq_en),
    .nmi_ack(s1_nmi_ack), .irq_ack(s1_irq_ack), .hcount(s1_hcount), .vcount(s1_vcount), .pix_x(s1_pix_x),
    .pix_y(s1_pix_y), .hb(s1_hb), .vb(s1_vb), .hs(s1_hs), .vs(s1_vs), .nmi_pend(s1_nmi_pend),
    .irq_pend(s1_irq_pend), .frame_cnt(s1_frame)
  );

  vball_video_timing #(
    .CNT_W(9), .H_TOTAL(16), .H_BLANK_END(1), .H_BLANK_ST(11), .H_SYNC_ST(12), .H_SYNC_END(14),
    .V_TOTAL(40), .V_BLANK_ST(34), .V_SYNC_ST(36), .V_SYNC_END(38), .NMI_LINE(34), .IRQ_LOG2(4),
    .SYNC_NEG(0)
  ) s2_dut (
    .clk(clk), .reset(s_reset), .ce_pix(s_ce), .flip(s_flip), .nmi_en(s_nmi_en), .irq_en(s_irq_en),
    .nmi_ack(s2_nmi_ack), .irq_ack(s2_irq_ack), .hcount(s2_hcount), .vcount(s2_vcount), .pix_x(s2_pix_x),
    .pix_y(s2_pix_y), .hb(s2_hb), .vb(s2_vb), .hs(s2_hs), .vs(s2_vs), .nmi_pend(s2_nmi_pend),
    .irq_pend(s2_irq_pend), .frame_cnt(s2_frame)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [49:0] d_snap();
    return {d_hcount, d_vcount, d_pix_x, d_pix_y, d_hb, d_vb, d_hs, d_vs, d_nmi, d_irq, d_frame};
  endfunction

  function automatic logic [37:0] d_pos();
    return {d_hcount, d_vcount, d_pix_x, d_pix_y, d_hb, d_hs};
  endfunction

  task automatic test_reset();
    d_reset = 1'b1; d_ce = 1'b1; d_nmi_en = 1'b1; d_irq_en = 1'b1;
    s_reset = 1'b1; s_ce = 1'b1;
    repeat (3) tick();
    checks++; if (d_hcount !== 9'd0) begin failures++; $display("FAIL reset_hcount got=%0d want=0", d_hcount); end
    checks++; if (d_vcount !== 9'd0) begin failures++; $display("FAIL reset_vcount got=%0d want=0", d_vcount); end
    checks++; if (d_pix_x !== 9'd0) begin failures++; $display("FAIL reset_pix_x got=%0d want=0", d_pix_x); end
    checks++; if (d_pix_y !== 9'd0) begin failures++; $display("FAIL reset_pix_y got=%0d want=0", d_pix_y); end
    checks++; if (d_hb !== 1'b1) begin failures++; $display("FAIL reset_hb got=%b want=1", d_hb); end
    checks++; if (d_vb !== 1'b0) begin failures++; $display("FAIL reset_vb got=%b want=0", d_vb); end
    checks++; if (d_hs !== 1'b1) begin failures++; $display("FAIL reset_hs got=%b want=1", d_hs); end
    checks++; if (d_vs !== 1'b1) begin failures++; $display("FAIL reset_vs got=%b want=1", d_vs); end
    checks++; if (d_nmi !== 1'b0) begin failures++; $display("FAIL reset_nmi got=%b want=0", d_nmi); end
    checks++; if (d_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b want=0", d_irq); end
    checks++; if (d_frame !== 8'd0) begin failures++; $display("FAIL reset_frame got=%0d want=0", d_frame); end
    checks++; if ({s2_hs, s2_vs} !== 2'b00) begin failures++; $display("FAIL reset_s2_sync got=%b want=00", {s2_hs, s2_vs}); end
    d_nmi_en = 1'b0; d_irq_en = 1'b0;
  endtask

  task automatic test_default_line();
    int hs_low0 = 0;
    int hs_low1 = 0;
    int bad = 0;
    int tt [10] = '{1, 240, 241, 297, 298, 329, 330, 400, 401, 799};
    logic [37:0] ev [10] = '{
      {9'd1,   9'd0, 9'd0,   9'd0, 1'b0, 1'b1},
      {9'd240, 9'd0, 9'd239, 9'd0, 1'b0, 1'b1},
      {9'd241, 9'd0, 9'd240, 9'd0, 1'b1, 1'b1},
      {9'd297, 9'd0, 9'd296, 9'd0, 1'b1, 1'b1},
      {9'd298, 9'd0, 9'd297, 9'd0, 1'b1, 1'b0},
      {9'd329, 9'd0, 9'd328, 9'd0, 1'b1, 1'b0},
      {9'd330, 9'd0, 9'd329, 9'd0, 1'b1, 1'b1},
      {9'd0,   9'd1, 9'd511, 9'd1, 1'b1, 1'b1},
      {9'd1,   9'd1, 9'd0,   9'd1, 1'b0, 1'b1},
      {9'd399, 9'd1, 9'd398, 9'd1, 1'b1, 1'b1}};
    d_reset = 1'b0;
    for (int t = 1; t <= 800; t++) begin
      tick();
      if (!d_hs) begin
        if (t < 400) hs_low0++; else hs_low1++;
      end
      if (d_vs !== 1'b1 || d_vb !== 1'b0) bad++;
      for (int k = 0; k < 10; k++) begin
        if (t == tt[k]) begin
          checks++;
          if (d_pos() !== ev[k]) begin failures++; $display("FAIL line_vec_t%0d got=%h want=%h", t, d_pos(), ev[k]); end
        end
      end
    end
    checks++; if (hs_low0 != 32) begin failures++; $display("FAIL hs_low_line0 got=%0d want=32", hs_low0); end
    checks++; if (hs_low1 != 32) begin failures++; $display("FAIL hs_low_line1 got=%0d want=32", hs_low1); end
    checks++; if (bad != 0) begin failures++; $display("FAIL vs_vb_active_lines bad=%0d want=0", bad); end
  endtask

  task automatic test_ce_third();
    logic [49:0] snap;
    logic [8:0]  h0;
    int guard = 0;
    for (int k = 0; k < 6; k++) begin
      snap = d_snap();
      d_ce = 1'b0;
      tick(); tick();
      checks++; if (d_snap() !== snap) begin failures++; $display("FAIL ce_hold%0d got=%h want=%h", k, d_snap(), snap); end
      h0 = d_hcount;
      d_ce = 1'b1;
      tick();
      d_ce = 1'b0;
      checks++; if (d_hcount !== h0 + 9'd1) begin failures++; $display("FAIL ce_step%0d got=%0d want=%0d", k, d_hcount, h0 + 9'd1); end
    end
    while (d_hcount != 9'd200 && guard < 1000) begin
      d_ce = (guard % 3 == 2);
      tick();
      guard++;
    end
    checks++; if (d_hcount !== 9'd200) begin failures++; $display("FAIL ce_reach_200 got=%0d want=200", d_hcount); end
    d_ce = 1'b0; d_reset = 1'b1;
    tick();
    checks++;
    if (d_snap() !== {36'd0, 4'b1011, 2'b00, 8'd0}) begin
      failures++; $display("FAIL midline_reset got=%h want=%h", d_snap(), {36'd0, 4'b1011, 2'b00, 8'd0});
    end
  endtask

  task automatic test_frame_s();
    int hs1_low = 0, vs1_low = 0, hs2_hi = 0, vs2_hi = 0;
    s_reset = 1'b0; s_ce = 1'b1;
    for (int t = 1; t <= 640; t++) begin
      tick();
      if (!s1_hs) hs1_low++;
      if (!s1_vs) vs1_low++;
      if (s2_hs) hs2_hi++;
      if (s2_vs) vs2_hi++;
      if (t == 10) begin checks++; if ({s1_hcount, s1_hb} !== {9'd10, 1'b0}) begin failures++; $display("FAIL s_hb_t10 got=%h want=%h", {s1_hcount, s1_hb}, {9'd10, 1'b0}); end end
      if (t == 11) begin checks++; if ({s1_hcount, s1_hb} !== {9'd11, 1'b1}) begin failures++; $display("FAIL s_hb_t11 got=%h want=%h", {s1_hcount, s1_hb}, {9'd11, 1'b1}); end end
      if (t == 543) begin checks++; if (s1_vb !== 1'b0) begin failures++; $display("FAIL s_vb_t543 got=%b want=0", s1_vb); end end
      if (t == 544) begin checks++; if (s1_vb !== 1'b1) begin failures++; $display("FAIL s_vb_t544 got=%b want=1", s1_vb); end end
      if (t == 639) begin checks++; if (s1_frame !== 8'd0) begin failures++; $display("FAIL frame_t639 got=%0d want=0", s1_frame); end end
      if (t == 640) begin
        checks++;
        if ({s1_frame, s1_hcount, s1_vcount} !== {8'd1, 9'd0, 9'd0}) begin
          failures++; $display("FAIL frame_t640 got=%h want=%h", {s1_frame, s1_hcount, s1_vcount}, {8'd1, 9'd0, 9'd0});
        end
      end
    end
    checks++; if (hs1_low != 80) begin failures++; $display("FAIL s1_hs_low got=%0d want=80", hs1_low); end
    checks++; if (vs1_low != 32) begin failures++; $display("FAIL s1_vs_low got=%0d want=32", vs1_low); end
    checks++; if (hs2_hi != 80) begin failures++; $display("FAIL s2_hs_high got=%0d want=80", hs2_hi); end
    checks++; if (vs2_hi != 32) begin failures++; $display("FAIL s2_vs_high got=%0d want=32", vs2_hi); end
  endtask

  task automatic test_irq_cadence();
    int n1 = 0, n2 = 0, r1 = -100, r2 = -100, bad = 0;
    logic p1 = 1'b0, p2 = 1'b0;
    s_irq_en = 1'b1;
    for (int t = 1; t <= 640; t++) begin
      tick();
      if (s1_irq_pend && !p1) begin
        r1 = t;
        if (s1_hcount !== 9'd0 || s1_vcount !== 9'(8 * n1 + 7)) bad++;
        n1++;
      end
      if (s2_irq_pend && !p2) begin
        r2 = t;
        if (s2_hcount !== 9'd0 || s2_vcount !== 9'(16 * n2 + 15)) bad++;
        n2++;
      end
      if (t == r1 + 2 && s1_irq_pend) bad++;
      if (t == r2 + 2 && s2_irq_pend) bad++;
      p1 = s1_irq_pend;
      p2 = s2_irq_pend;
      s1_irq_ack = (t == r1 + 1);
      s2_irq_ack = (t == r2 + 1);
    end
    s_irq_en = 1'b0; s1_irq_ack = 1'b0; s2_irq_ack = 1'b0;
    checks++; if (n1 != 5) begin failures++; $display("FAIL s1_irq_rises got=%0d want=5", n1); end
    checks++; if (n2 != 2) begin failures++; $display("FAIL s2_irq_rises got=%0d want=2", n2); end
    checks++; if (bad != 0) begin failures++; $display("FAIL irq_position_or_ack bad=%0d want=0", bad); end
  endtask

  task automatic test_nmi();
    int bad1 = 0, bad2 = 0;
    s_nmi_en = 1'b1;
    for (int t = 1; t <= 1280; t++) begin
      tick();
      if (s1_nmi_pend !== (t >= 544 && t <= 1190)) bad1++;
      if (s2_nmi_pend !== (t >= 544 && t <= 1270)) bad2++;
      if (t == 1184) begin checks++; if (s1_nmi_pend !== 1'b1) begin failures++; $display("FAIL nmi_set_beats_ack got=%b want=1", s1_nmi_pend); end end
      s1_nmi_ack = (t == 1183);
      if (t == 1190) begin
        s_ce = 1'b0; s1_nmi_ack = 1'b1;
        tick();
        checks++;
        if ({s1_nmi_pend, s1_hcount, s1_vcount} !== {1'b0, 9'd6, 9'd34}) begin
          failures++; $display("FAIL nmi_ack_no_ce got=%h want=%h", {s1_nmi_pend, s1_hcount, s1_vcount}, {1'b0, 9'd6, 9'd34});
        end
        s_ce = 1'b1; s1_nmi_ack = 1'b0;
      end
      if (t == 1270) s_nmi_en = 1'b0;
      if (t == 1271) s_nmi_en = 1'b1;
    end
    checks++; if (bad1 != 0) begin failures++; $display("FAIL s1_nmi_profile bad=%0d want=0", bad1); end
    checks++; if (bad2 != 0) begin failures++; $display("FAIL s2_nmi_profile_en_clear bad=%0d want=0", bad2); end
  endtask

  task automatic test_flip();
    int bad = 0;
    int tt [6] = '{639, 641, 650, 740, 1169, 1281};
    logic [17:0] ev [6] = '{{9'd14, 9'd39}, {9'd9, 9'd33}, {9'd0, 9'd33}, {9'd6, 9'd27}, {9'd9, 9'd0}, {9'd0, 9'd0}};
    for (int t = 1; t <= 1281; t++) begin
      tick();
      if (t < 640 && (t % 16) >= 1 && (t % 16) <= 10 && (t / 16) < 34) begin
        if (s1_pix_x !== 9'((t % 16) - 1) || s1_pix_y !== 9'(t / 16)) bad++;
      end
      for (int k = 0; k < 6; k++) begin
        if (t == tt[k]) begin
          checks++;
          if ({s1_pix_x, s1_pix_y} !== ev[k]) begin failures++; $display("FAIL flip_vec_t%0d got=%h want=%h", t, {s1_pix_x, s1_pix_y}, ev[k]); end
        end
      end
      if (t == 320) s_flip = 1'b1;
      if (t == 700) s_flip = 1'b0;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL flip_no_tear bad=%0d want=0", bad); end
  endtask

  initial begin
    d_reset = 1'b1; d_ce = 1'b0; d_flip = 1'b0; d_nmi_en = 1'b0; d_irq_en = 1'b0; d_nmi_ack = 1'b0; d_irq_ack = 1'b0;
    s_reset = 1'b1; s_ce = 1'b0; s_flip = 1'b0; s_nmi_en = 1'b0; s_irq_en = 1'b0;
    s1_nmi_ack = 1'b0; s1_irq_ack = 1'b0; s2_nmi_ack = 1'b0; s2_irq_ack = 1'b0;
    test_reset();
    test_default_line();
    test_ce_third();
    test_frame_s();
    test_irq_cadence();
    test_nmi();
    test_flip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
